dpc_bp_report_ctrl: RTL
=======================

// Module: dpc_bp_report_ctrl
// PURPOSE
//  Session controller for DPC auto bad-pixel detection. Arms DPC_Detector for N whole frames
//  (SOF-aligned), drives its enable and bp_ready, and buffers {type,y,x} reports in a FIFO.
//  The host drains the FIFO over a ready/valid port. Sits between DPC_Detector and the AXI-Lite regs.
// PARAMETERS
//  CNT_WIDTH       10    coordinate width, matches detector
//  AUTO_BP_BIT     8     FIFO addr bits; depth = 2**AUTO_BP_BIT
//  FRM_BIT         4     width of frame-count request
//  DRAIN_CYCLES    4     cycles after last frame_done still accepting reports (covers detector pipe)
//  TIMEOUT_CYCLES  2**24 watchdog limit; used only with DPC_RPT_TIMEOUT_EN
// PORTS
//  aclk          in   1            clock
//  aresetn       in   1            async active-low reset
//  start         in   1            pulse: begin session (flushes FIFO, clears counters)
//  abort         in   1            pulse: return to IDLE, flush FIFO
//  frame_num     in   FRM_BIT      frames to capture; 0 treated as 1; latched on start
//  sof_pulse     in   1            1-cycle frame start from pixel stream
//  frame_done    in   1            detector frame_detection_done
//  bp_valid      in   1            detector auto_bp_valid
//  bp_x, bp_y    in   CNT_WIDTH    detector coordinates
//  bp_type       in   1            0 = dead, 1 = stuck
//  bp_ready      out  1            to detector; = FIFO not full (combinational)
//  det_enable    out  1            to detector enable (registered)
//  m_rpt_tvalid  out  1            FIFO not empty (FWFT)
//  m_rpt_tdata   out  2*CNT_WIDTH+1  {type, y, x}
//  m_rpt_tready  in   1            host pop
//  busy          out  1            state is WAIT_SOF, CAPTURE or DRAIN
//  done          out  1            level, state DONE
//  timeout       out  1            sticky; session ended by watchdog
//  overflow      out  1            sticky; at least one report dropped
//  ovf_cnt       out  16           dropped reports, saturates at 0xFFFF
//  rpt_cnt       out  AUTO_BP_BIT+1  reports accepted this session
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; bp_ready = 1 (FIFO empty).
//  States IDLE -> WAIT_SOF -> CAPTURE -> DRAIN -> DONE:
//   - IDLE: start -> WAIT_SOF; frames_left = max(frame_num,1); FIFO and all counters/flags cleared.
//   - WAIT_SOF: det_enable = 1 (registered, visible next cycle); bp_valid is discarded.
//     sof_pulse -> CAPTURE.
//   - CAPTURE: push on bp_valid && bp_ready.
//     frame_done: frames_left -= 1; if it reaches 0 -> DRAIN, det_enable = 0.
//   - DRAIN: still pushes; after DRAIN_CYCLES cycles -> DONE.
//   - DONE: done = 1. start -> WAIT_SOF with the same clearing as IDLE. FIFO is readable in every state.
//  Report acceptance:
//   - Push accepted only if count < depth before the cycle; a same-cycle pop does not free a slot.
//   - bp_valid && !bp_ready in CAPTURE/DRAIN: overflow = 1, ovf_cnt++ (saturating).
//   - Push and pop in the same cycle: count unchanged, data order preserved.
//  Pointers wrap mod depth; rpt_cnt saturates at 2**(AUTO_BP_BIT+1)-1.
//  Priority: abort > start. Abort in any state -> IDLE next cycle: det_enable = 0, FIFO flushed,
//    m_rpt_tvalid = 0; sticky flags kept.
//  start while busy is ignored. sof_pulse inside CAPTURE is ignored; frames are counted only by frame_done.
//  frame_done together with bp_valid in the same cycle: the report is pushed before the state moves on.
//  Latency: bp_valid -> m_rpt_tvalid 1 cycle when the FIFO was empty.
// CONFIGURATION
//  DPC_RPT_TIMEOUT_EN defined:
//   - Watchdog counts cycles in WAIT_SOF/CAPTURE; cleared on sof_pulse, frame_done and state entry.
//   - Reaching TIMEOUT_CYCLES -> DONE directly (DRAIN skipped), timeout = 1, det_enable = 0.
//  Not defined: no counter is built; timeout is tied to 0.
// TESTING
//  1. start, frame_num=1; sof; 3 reports (5,7,0) (9,7,1) (3,8,0); frame_done
//     -> DONE after DRAIN_CYCLES; FIFO pops those 3 in order; rpt_cnt=3.
//  2. frame_num=2; 1 report per frame
//     -> stays CAPTURE after the first frame_done; DONE after the second; rpt_cnt=2.
//  3. m_rpt_tready=0; depth+3 reports
//     -> bp_ready low at full; ovf_cnt=3; overflow=1; FIFO holds the first depth reports.
//  4. bp_valid in WAIT_SOF before sof -> not stored; det_enable=1 from the cycle after start.
//  5. abort mid-CAPTURE with 4 reports queued
//     -> IDLE next cycle; m_rpt_tvalid=0; det_enable=0. start+abort in the same cycle -> IDLE.
//  6. (DPC_RPT_TIMEOUT_EN, TIMEOUT_CYCLES=100) start, no sof -> DONE at cycle 100; timeout=1.

Source files
------------

// File: rtl/dpc_bp_report_ctrl.sv
// dpc_bp_report_ctrl: session controller for DPC auto bad-pixel detection.
// Arms the detector for a number of whole frames, aligned to SOF. Buffers the
// {type, y, x} reports in a first-word-fall-through FIFO. The host drains that
// FIFO over a ready/valid port.
// Optional feature: define DPC_RPT_TIMEOUT_EN to build the session watchdog.
module dpc_bp_report_ctrl #(
    parameter int CNT_WIDTH    = 10,
    parameter int AUTO_BP_BIT  = 8,
    parameter int FRM_BIT      = 4,
    parameter int DRAIN_CYCLES = 4
`ifdef DPC_RPT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**24
`endif
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FRM_BIT-1:0]     frame_num,
    input  logic                   sof_pulse,
    input  logic                   frame_done,
    input  logic                   bp_valid,
    input  logic [CNT_WIDTH-1:0]   bp_x,
    input  logic [CNT_WIDTH-1:0]   bp_y,
    input  logic                   bp_type,
    output logic                   bp_ready,
    output logic                   det_enable,
    output logic                   m_rpt_tvalid,
    output logic [2*CNT_WIDTH:0]   m_rpt_tdata,
    input  logic                   m_rpt_tready,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   overflow,
    output logic [15:0]            ovf_cnt,
    output logic [AUTO_BP_BIT:0]   rpt_cnt
);

    localparam int DW    = 2*CNT_WIDTH + 1;
    localparam int DEPTH = 2**AUTO_BP_BIT;
    localparam int DCW   = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [FRM_BIT-1:0]     frames_left;
    logic [DCW-1:0]         drain_cnt;
    logic [AUTO_BP_BIT-1:0] wr_ptr, rd_ptr;
    logic [AUTO_BP_BIT:0]   count;
    logic [DW-1:0]          mem [DEPTH];
    logic                   start_ok, accepting, push, drop, pop, flush, wd_expire;

    // A new session starts only from IDLE or DONE, and abort overrides it.
    assign start_ok  = start && !abort && (state == S_IDLE || state == S_DONE);
    assign accepting = (state == S_CAPTURE) || (state == S_DRAIN);
    // The FIFO is full when the count MSB is set, because count never exceeds DEPTH.
    assign bp_ready  = !count[AUTO_BP_BIT];
    assign push      = accepting && bp_valid && bp_ready;
    assign drop      = accepting && bp_valid && !bp_ready;
    assign pop       = m_rpt_tvalid && m_rpt_tready;
    assign flush     = abort || start_ok;

    assign m_rpt_tvalid = (count != '0);
    assign m_rpt_tdata  = mem[rd_ptr];
    assign busy         = (state == S_WAIT_SOF) || (state == S_CAPTURE) || (state == S_DRAIN);
    assign done         = (state == S_DONE);

`ifdef DPC_RPT_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WDW-1:0] wd_cnt;
    logic           timeout_q;

    // The watchdog fires only when neither sof_pulse nor frame_done clears it in the same cycle.
    assign wd_expire = (state == S_WAIT_SOF || state == S_CAPTURE) && !sof_pulse && !frame_done
                       && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    // The watchdog counts cycles in WAIT_SOF/CAPTURE and restarts on activity or on a state change.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_nxt != state || sof_pulse || frame_done)
                wd_cnt <= '0;
            else if (state == S_WAIT_SOF || state == S_CAPTURE)
                wd_cnt <= wd_cnt + 1'b1;
            if (start_ok)
                timeout_q <= 1'b0;
            else if (wd_expire && !abort)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next-state logic for the session FSM; abort takes priority over everything else.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (start)      state_nxt = S_WAIT_SOF;
            S_WAIT_SOF:     if (sof_pulse)  state_nxt = S_CAPTURE;
            S_CAPTURE:      if (frame_done && frames_left == FRM_BIT'(1)) state_nxt = S_DRAIN;
            S_DRAIN:        if (drain_cnt == DCW'(DRAIN_CYCLES - 1))      state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
        if (wd_expire) state_nxt = S_DONE;
        if (abort)     state_nxt = S_IDLE;
    end

    // State register, frame and drain counters, and the registered detector enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state       <= S_IDLE;
            frames_left <= '0;
            drain_cnt   <= '0;
            det_enable  <= 1'b0;
        end else begin
            state      <= state_nxt;
            det_enable <= (state_nxt == S_WAIT_SOF) || (state_nxt == S_CAPTURE);
            if (start_ok)
                frames_left <= (frame_num == '0) ? FRM_BIT'(1) : frame_num;
            else if (state == S_CAPTURE && frame_done)
                frames_left <= frames_left - 1'b1;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    // FIFO pointers and occupancy; a flush empties the FIFO without touching the storage.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge aclk) begin
        // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
        if (push) mem[wr_ptr] <= {bp_type, bp_y, bp_x};
    end

    // Session statistics: accepted reports and dropped reports, cleared on start, kept on abort.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rpt_cnt  <= '0;
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else if (start_ok) begin
            rpt_cnt  <= '0;
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (push && rpt_cnt != '1) rpt_cnt <= rpt_cnt + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

endmodule
